// File: rtl/nn_pkg.sv
// ============================================================================
// Module      : nn_pkg
// Description : Shared types and default sizes for the network output stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_pkg;

    localparam int NN_DATA_WIDTH  = 16;
    localparam int NN_NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

endpackage

`default_nettype wire

// File: rtl/argmax_cmp.sv
// ============================================================================
// Module      : argmax_cmp
// Description : Single argmax step; a candidate replaces the incumbent only
//               when strictly greater (signed), so ties keep the lower index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module argmax_cmp
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = NN_DATA_WIDTH,
    parameter int IDX_WIDTH  = 4
) (
    input  logic [DATA_WIDTH-1:0] cand,
    input  logic [IDX_WIDTH-1:0]  cand_idx,
    input  logic [DATA_WIDTH-1:0] cur_max,
    input  logic [IDX_WIDTH-1:0]  cur_idx,
    output logic [DATA_WIDTH-1:0] next_max,
    output logic [IDX_WIDTH-1:0]  next_idx
);

    logic w_take;

    assign w_take   = $signed(cand) > $signed(cur_max);
    assign next_max = w_take ? cand     : cur_max;
    assign next_idx = w_take ? cand_idx : cur_idx;

endmodule

`default_nettype wire

// File: rtl/argmax_unit.sv
// ============================================================================
// Module      : argmax_unit
// Description : Captures the final layer's outputs and scans them serially to
//               report the index/value of the largest signed activation.
//               Optional o_onehot output enabled by ARGMAX_ONEHOT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module argmax_unit
    import nn_pkg::*;
#(
    parameter int NUM_INPUT  = NN_NUM_CLASSES,
    parameter int DATA_WIDTH = NN_DATA_WIDTH,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_INPUT-1:0]            i_valid,
    input  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data,
    output logic                            o_ready,
    output logic                            o_valid,
    output logic [IDX_WIDTH-1:0]            o_idx,
    output logic [DATA_WIDTH-1:0]           o_max,
`ifdef ARGMAX_ONEHOT_EN
    output logic [NUM_INPUT-1:0]            o_onehot,
`endif
    output logic                            o_overrun
);

    localparam logic [IDX_WIDTH-1:0] c_last  = IDX_WIDTH'(NUM_INPUT - 1);
    localparam logic [IDX_WIDTH-1:0] c_first = (NUM_INPUT > 1) ? IDX_WIDTH'(1) : '0;

    argmax_state_t r_state;
    argmax_state_t w_state_nxt;

    logic [NUM_INPUT*DATA_WIDTH-1:0] r_buf;
    logic [IDX_WIDTH-1:0]            r_cnt;
    logic [DATA_WIDTH-1:0]           r_cur_max;
    logic [IDX_WIDTH-1:0]            r_cur_idx;
    logic [DATA_WIDTH-1:0]           w_cand;
    logic [DATA_WIDTH-1:0]           w_next_max;
    logic [IDX_WIDTH-1:0]            w_next_idx;
    logic                            w_capture;
    logic                            w_last;
    logic                            w_unused;

    // Only lane 0 triggers capture; the other valids exist for bus compatibility.
    assign w_unused  = &{1'b0, i_valid};
    assign o_ready   = (r_state == IDLE) || (r_state == DONE);
    assign o_valid   = (r_state == DONE);
    assign w_capture = o_ready && i_valid[0];
    assign w_last    = (r_cnt == c_last);
    assign w_cand    = r_buf[r_cnt*DATA_WIDTH +: DATA_WIDTH];

    argmax_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_cmp (
        .cand     (w_cand),
        .cand_idx (r_cnt),
        .cur_max  (r_cur_max),
        .cur_idx  (r_cur_idx),
        .next_max (w_next_max),
        .next_idx (w_next_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_valid[0]) begin
                    w_state_nxt = (NUM_INPUT == 1) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_valid[0]) begin
                    w_state_nxt = (NUM_INPUT == 1) ? DONE : SCAN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef ARGMAX_ONEHOT_EN
    logic [NUM_INPUT-1:0] w_onehot;

    for (genvar k = 0; k < NUM_INPUT; k++) begin : g_onehot
        assign w_onehot[k] = (w_next_idx == IDX_WIDTH'(k));
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf     <= '0;
            r_cnt     <= '0;
            r_cur_max <= '0;
            r_cur_idx <= '0;
            o_idx     <= '0;
            o_max     <= '0;
            o_overrun <= 1'b0;
`ifdef ARGMAX_ONEHOT_EN
            o_onehot  <= '0;
`endif
        end else if (w_capture) begin
            r_buf     <= i_data;
            r_cur_max <= i_data[DATA_WIDTH-1:0];
            r_cur_idx <= '0;
            r_cnt     <= c_first;
            // A single-element bus has nothing to scan: publish element 0 directly.
            if (NUM_INPUT == 1) begin
                o_idx <= '0;
                o_max <= i_data[DATA_WIDTH-1:0];
`ifdef ARGMAX_ONEHOT_EN
                o_onehot <= NUM_INPUT'(1);
`endif
            end
        end else if (r_state == SCAN) begin
            if (i_valid[0]) begin
                o_overrun <= 1'b1;
            end
            r_cur_max <= w_next_max;
            r_cur_idx <= w_next_idx;
            if (w_last) begin
                o_idx <= w_next_idx;
                o_max <= w_next_max;
`ifdef ARGMAX_ONEHOT_EN
                o_onehot <= w_onehot;
`endif
            end else begin
                r_cnt <= r_cnt + IDX_WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/argmax_unit.md
Name: argmax_unit

Overview:
- Consumes the parallel output bus of the final fully-connected layer: 10 neurons × dataWidth, plus a per-neuron valid.
- Captures all values in one cycle, then scans them sequentially to find the index and value of the largest signed activation.
- The result is the network's classification, presented to the PS/AXI readback logic as a one-cycle valid pulse.

Parameters:
- NUM_INPUT, 10, number of neuron outputs on the input bus (≥1).
- DATA_WIDTH, 16, width of each neuron output, signed two's-complement fixed point.
- IDX_WIDTH, 4, width of the index output; must satisfy 2**IDX_WIDTH ≥ NUM_INPUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  NUM_INPUT  per-neuron valids; capture triggers on i_valid[0] only, because all neurons complete together.
- i_data  in  NUM_INPUT*DATA_WIDTH  element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_ready  out  1  high when a capture will be accepted this cycle.
- o_valid  out  1  one-cycle result pulse.
- o_idx  out  IDX_WIDTH  index of the maximum; held until the next result.
- o_max  out  DATA_WIDTH  value of the maximum; held until the next result.
- o_overrun  out  1  sticky: an i_valid[0] arrived while the unit was not ready; cleared only by rst.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - o_valid=0, o_idx=0, o_max=0, o_overrun=0, o_ready=1.
  - Capture buffer and counter cleared.
- States: IDLE, SCAN, DONE. o_ready = (state==IDLE || state==DONE).
- IDLE:
  - On i_valid[0] in cycle T: register all NUM_INPUT elements into a buffer; cur_max=elem0, cur_idx=0, cnt=1.
  - Next state is SCAN, or DONE directly if NUM_INPUT==1.
- SCAN:
  - Each cycle, compare buf[cnt] against cur_max as signed values.
  - If buf[cnt] > cur_max (strictly greater), update cur_max and cur_idx=cnt.
  - Ties keep the lower index.
  - cnt increments; when cnt==NUM_INPUT-1 is evaluated, next state is DONE.
- DONE:
  - Lasts exactly one cycle; o_valid=1, with o_idx/o_max registered from the final compare.
  - If i_valid[0] is high in DONE, capture as in IDLE and go to SCAN (back-to-back supported). Otherwise go to IDLE.
- Latency: i_valid[0] in cycle T gives o_valid in cycle T+NUM_INPUT, i.e. cycle T+10 at default.
- Throughput: one classification per NUM_INPUT cycles.
- i_valid[0] while in SCAN: ignored, no capture; o_overrun set to 1. Buffer contents stay unchanged during SCAN.
- i_valid[k] for k≠0 is ignored; it exists only for bus compatibility.
- rst asserted mid-SCAN: immediate return to IDLE, all outputs to reset values, no o_valid pulse.
- Width rules:
  - Comparisons are signed over DATA_WIDTH; no widening or saturation.
  - cnt is IDX_WIDTH bits and never wraps past NUM_INPUT-1.
- Between results, o_idx/o_max hold the last result.

Optional Feature:
- Macro ARGMAX_ONEHOT_EN.
- When defined:
  - Adds output o_onehot [NUM_INPUT-1:0].
  - Registered together with o_idx; bit o_idx is set, all others 0.
  - Reset value is all-zero; held between results like o_idx.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package nn_pkg:
  - argmax_state_t enum {IDLE, SCAN, DONE}.
  - Default constants NN_DATA_WIDTH=16 and NN_NUM_CLASSES=10, reused by the layer wrappers.
- One sub-module argmax_cmp, purely combinational: inputs cand, cand_idx, cur_max, cur_idx; outputs next_max, next_idx.
  - Signed strict greater-than, with ties going to the incumbent.
- The FSM, buffer, counter and output registers live in argmax_unit.

Test Plan:
- Reset then single capture:
  - Stimulus: i_data = {0x0010, 0x0200, 0x0030, 0x0040, 0x0050, 0x0060, 0x0070, 0x0080, 0x0090, 0x00A0} (elem9…elem0), i_valid=all-ones at T.
  - Response: o_valid only at T+10; o_idx=8; o_max=0x0200.
- Negative values:
  - Stimulus: all elements 0xFF00 except elem3=0xFFF0.
  - Response: o_idx=3, o_max=0xFFF0.
  - Also checks signed compare: elem7=0x8000 must never win.
- Tie:
  - Stimulus: elem2 = elem6 = 0x0100, others 0.
  - Response: o_idx=2.
  - Also: all elements equal gives o_idx=0.
- Back-to-back:
  - Stimulus: second i_valid[0] asserted in the DONE cycle of the first.
  - Response: second o_valid exactly 10 cycles after the first; o_overrun stays 0.
- Overrun:
  - Stimulus: i_valid[0] at T+4 during SCAN with different data.
  - Response: o_overrun=1 from T+5; the result at T+10 reflects the original data; no extra o_valid.
- Reset mid-SCAN:
  - Stimulus: rst pulsed at T+5, asynchronously between edges.
  - Response: outputs zero immediately; no o_valid at T+10; o_ready=1.
  - With ARGMAX_ONEHOT_EN defined, scenario 1 also requires o_onehot=0x100.
